// File: rtl/dff_stim_checker.sv
// Stimulus driver and checker for a rising-edge D flip-flop: drives d after LFSR-timed delays and checks q.
// Optional macro DFF_STIM_CHECK_EN adds the HOLD/CHECK states, mismatch pulse and error counter.
module dff_stim_checker #(
    parameter int unsigned NUM_ITER  = 5,
    parameter int unsigned DELAY_W   = 3,
    parameter logic [7:0]  LFSR_SEED = 8'hA5,
    parameter int unsigned ERR_W     = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             q,
    output logic             d,
    output logic             busy,
    output logic             done,
    output logic             mismatch,
    output logic [ERR_W-1:0] err_count,
    output logic [7:0]       iter
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_WAIT  = 3'd1,
        S_DRIVE = 3'd2,
`ifdef DFF_STIM_CHECK_EN
        S_HOLD  = 3'd3,
        S_CHECK = 3'd4,
`endif
        S_DONE  = 3'd5
    } state_t;

    state_t             state;
    logic [7:0]         lfsr;
    logic [DELAY_W-1:0] delay_cnt;
    logic [7:0]         lfsr_next;
    logic               last_iter;

    // Galois right-shift LFSR, taps 8'hB8
    assign lfsr_next = {1'b0, lfsr[7:1]} ^ (lfsr[0] ? 8'hB8 : 8'h00);
    assign last_iter = (iter == 8'(NUM_ITER - 1));

`ifdef DFF_STIM_CHECK_EN
    logic expected;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            lfsr      <= LFSR_SEED;
            delay_cnt <= '0;
            d         <= 1'b0;
            expected  <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            mismatch  <= 1'b0;
            err_count <= '0;
            iter      <= 8'd0;
        end else begin
            done     <= 1'b0;
            mismatch <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        delay_cnt <= lfsr[DELAY_W-1:0];
                        lfsr      <= lfsr_next;
                        iter      <= 8'd0;
                        err_count <= '0;
                        busy      <= 1'b1;
                        state     <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (delay_cnt == '0) state <= S_DRIVE;
                    else                 delay_cnt <= delay_cnt - DELAY_W'(1);
                end
                S_DRIVE: begin
                    d        <= iter[0];
                    expected <= iter[0];
                    state    <= S_HOLD;
                end
                S_HOLD: state <= S_CHECK;
                S_CHECK: begin
                    if (q != expected) begin
                        mismatch <= 1'b1;
                        if (err_count != {ERR_W{1'b1}}) err_count <= err_count + ERR_W'(1);
                    end
                    if (last_iter) begin
                        done  <= 1'b1;
                        state <= S_DONE;
                    end else begin
                        iter      <= iter + 8'd1;
                        delay_cnt <= lfsr[DELAY_W-1:0];
                        lfsr      <= lfsr_next;
                        state     <= S_WAIT;
                    end
                end
                S_DONE: begin
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
            endcase
        end
    end
`else
    logic unused_q;

    assign unused_q  = q;
    assign mismatch  = 1'b0;
    assign err_count = '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            lfsr      <= LFSR_SEED;
            delay_cnt <= '0;
            d         <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            iter      <= 8'd0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        delay_cnt <= lfsr[DELAY_W-1:0];
                        lfsr      <= lfsr_next;
                        iter      <= 8'd0;
                        busy      <= 1'b1;
                        state     <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (delay_cnt == '0) state <= S_DRIVE;
                    else                 delay_cnt <= delay_cnt - DELAY_W'(1);
                end
                // Without checking, DRIVE closes the transfer itself
                S_DRIVE: begin
                    d <= iter[0];
                    if (last_iter) begin
                        done  <= 1'b1;
                        state <= S_DONE;
                    end else begin
                        iter      <= iter + 8'd1;
                        delay_cnt <= lfsr[DELAY_W-1:0];
                        lfsr      <= lfsr_next;
                        state     <= S_WAIT;
                    end
                end
                S_DONE: begin
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
            endcase
        end
    end
`endif

endmodule

// File: tb/tb_dff_stim_checker.sv
// Directed bench for dff_stim_checker: real flip-flop, q tied 0, and q tied 1 with a saturating 2-bit counter.
module tb_dff_stim_checker;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic start = 1'b0;

    always #5 clk = ~clk;

    logic       d_m, busy_m, done_m, mm_m;
    logic [7:0] err_m, iter_m;
    logic       q_ff;
    logic       d_a, busy_a, done_a, mm_a;
    logic [7:0] err_a, iter_a;
    logic       d_b, busy_b, done_b, mm_b;
    logic [1:0] err_b;
    logic [7:0] iter_b;

    int n_tests = 0;
    int n_fail  = 0;

`ifdef DFF_STIM_CHECK_EN
    localparam int DONE_M = 36;
    localparam int DONE_B = 70;
    localparam int MM0    = 16;
    localparam int MM1    = 31;
    localparam int NMM    = 2;
    localparam int ERR_A  = 2;
    localparam int ERR_B  = 3;
    localparam int DCYC [10] = '{7, 8, 13, 14, 22, 23, 28, 29, 33, 34};
`else
    localparam int DONE_M = 26;
    localparam int DONE_B = 50;
    localparam int MM0    = 0;
    localparam int MM1    = 0;
    localparam int NMM    = 0;
    localparam int ERR_A  = 0;
    localparam int ERR_B  = 0;
    localparam int DCYC [10] = '{7, 8, 11, 12, 18, 19, 22, 23, 25, 26};
`endif
    localparam int DVAL [10] = '{0, 0, 0, 1, 1, 0, 0, 1, 1, 0};

    dff_stim_checker u_dut_ff (
        .clk(clk), .rst_n(rst_n), .start(start), .q(q_ff),
        .d(d_m), .busy(busy_m), .done(done_m), .mismatch(mm_m),
        .err_count(err_m), .iter(iter_m)
    );

    dff_stim_checker u_dut_q0 (
        .clk(clk), .rst_n(rst_n), .start(start), .q(1'b0),
        .d(d_a), .busy(busy_a), .done(done_a), .mismatch(mm_a),
        .err_count(err_a), .iter(iter_a)
    );

    dff_stim_checker #(.NUM_ITER(10), .ERR_W(2)) u_dut_q1 (
        .clk(clk), .rst_n(rst_n), .start(start), .q(1'b1),
        .d(d_b), .busy(busy_b), .done(done_b), .mismatch(mm_b),
        .err_count(err_b), .iter(iter_b)
    );

    // Flip-flop under check for the main instance
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) q_ff <= 1'b0;
        else        q_ff <= d_m;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // One start from a freshly reset state; optional extra start pulse at cycle pulse_at
    task automatic do_run(input string name, input int pulse_at);
        int dn_m = 0, dn_b = 0, first_m = 0, first_b = 0;
        int mm_cnt_a = 0, mm_cnt_m = 0, di = 0;
        int mm_at [2] = '{0, 0};
        @(negedge clk);
        start = 1'b1;
        for (int k = 1; k <= 120; k++) begin
            @(negedge clk);
            if (k == 1) begin
                start = 1'b0;
                chk({name, "_busy_start"}, 32'(busy_m), 32'd1);
            end
            if (k == pulse_at) start = 1'b1;
            else if (k == pulse_at + 1) start = 1'b0;
            if (di < 10 && k == DCYC[di]) begin
                chk($sformatf("%s_d_c%0d", name, k), 32'(d_m), 32'(DVAL[di]));
                di++;
            end
            if (done_m) begin
                if (dn_m == 0) first_m = k;
                dn_m++;
            end
            if (done_b) begin
                if (dn_b == 0) first_b = k;
                dn_b++;
            end
            if (mm_a) begin
                if (mm_cnt_a < 2) mm_at[mm_cnt_a] = k;
                mm_cnt_a++;
            end
            if (mm_m) mm_cnt_m++;
            if (k == DONE_M + 1) chk({name, "_busy_after_done"}, 32'(busy_m), 32'd0);
        end
        chk({name, "_done_cnt_m"},   32'(dn_m), 32'd1);
        chk({name, "_done_cyc_m"},   32'(first_m), 32'(DONE_M));
        chk({name, "_done_cnt_b"},   32'(dn_b), 32'd1);
        chk({name, "_done_cyc_b"},   32'(first_b), 32'(DONE_B));
        chk({name, "_mm_cnt_m"},     32'(mm_cnt_m), 32'd0);
        chk({name, "_mm_cnt_a"},     32'(mm_cnt_a), 32'(NMM));
        chk({name, "_mm0_cyc_a"},    32'(mm_at[0]), 32'(MM0));
        chk({name, "_mm1_cyc_a"},    32'(mm_at[1]), 32'(MM1));
        chk({name, "_err_m"},        32'(err_m), 32'd0);
        chk({name, "_err_a"},        32'(err_a), 32'(ERR_A));
        chk({name, "_err_b"},        32'(err_b), 32'(ERR_B));
        chk({name, "_iter_m"},       32'(iter_m), 32'd4);
        chk({name, "_iter_b"},       32'(iter_b), 32'd9);
        chk({name, "_d_final"},      32'(d_m), 32'd0);
    endtask

    initial begin
        int dn;
        // Reset held with random start
        rst_n = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            start = 1'($urandom);
            chk("rst_hold_m", 32'({d_m, busy_m, done_m, mm_m, err_m, iter_m}), 32'd0);
            chk("rst_hold_b", 32'({d_b, busy_b, done_b, mm_b, err_b, iter_b}), 32'd0);
        end
        @(negedge clk);
        start = 1'b0;
        rst_n = 1'b1;

        do_run("run1", 0);

        // Fresh reset, then a start pulse during WAIT of transfer 2
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        do_run("run2", 10);

        // Abort mid-run with asynchronous reset
        @(negedge clk);
        start = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            start = 1'b0;
        end
        chk("abort_busy_before", 32'(busy_m), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("abort_outputs", 32'({d_m, busy_m, done_m, mm_m, err_m, iter_m}), 32'd0);
        chk("abort_busy_b", 32'(busy_b), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        dn = 0;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            if (done_m || done_b) dn++;
        end
        chk("abort_no_done", 32'(dn), 32'd0);

        do_run("run3", 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/dff_stim_checker.md
# dff_stim_checker

Synthesizable stimulus driver and checker for the rising-edge D flip-flop. It is the driving end of the flip-flop's data interface. On each `start` it runs `NUM_ITER` transfers; each transfer waits a pseudo-random delay, drives `d`, then compares the flip-flop's `q` against the driven value. It sits beside the flip-flop in self-test builds: `d` feeds the flip-flop's `D`, and the flip-flop's `Q` feeds `q`.

## Interface
- `NUM_ITER`, default 5: transfers per run, range 1..255.
- `DELAY_W`, default 3: width of the random delay field, range 1..8.
- `LFSR_SEED`, default 8'hA5: LFSR reset value; must be nonzero.
- `ERR_W`, default 8: width of the error counter.
- `clk` in 1: main clock; all state updates on the rising edge.
- `rst_n` in 1: reset, asynchronous and active-low.
- `start` in 1: run request, sampled only in IDLE.
- `q` in 1: flip-flop output under check.
- `d` out 1: data driven to the flip-flop; registered.
- `busy` out 1: high in every state except IDLE.
- `done` out 1: one-cycle pulse at the end of a run.
- `mismatch` out 1: one-cycle pulse when a check fails; registered.
- `err_count` out ERR_W: saturating count of failed checks.
- `iter` out 8: index of the current transfer.

## Operation
- Reset values: `d`=0, `busy`=0, `done`=0, `mismatch`=0, `err_count`=0, `iter`=0.
- Reset also sets the LFSR to `LFSR_SEED`, `delay_cnt` to 0 and the state to IDLE.
- LFSR: 8-bit Galois, right shift. `next = (lfsr>>1) ^ (lfsr[0] ? 8'hB8 : 0)`.
- LFSR advance: one step per delay load, and at no other time. It is not reset by `start`, so successive runs continue the sequence.
- Delay load: `delay_cnt <= lfsr[DELAY_W-1:0]`, using the value before the advance.
- States and transitions:
  - IDLE: `start`=1 → load delay, clear `iter` and `err_count`, go to WAIT.
  - WAIT: `delay_cnt`==0 → DRIVE; otherwise decrement `delay_cnt`.
  - DRIVE: `d <= iter[0]`, `expected <= iter[0]`, go to HOLD. `d` changes at the edge leaving DRIVE.
  - HOLD: one cycle, in which the flip-flop captures `d`. Go to CHECK.
  - CHECK: compare `q` with `expected`.
    - On inequality: `mismatch` is 1 next cycle, and `err_count` increments, saturating at all-ones.
    - If `iter`==`NUM_ITER`-1 → DONE.
    - Otherwise `iter` increments, a new delay loads, and the FSM returns to WAIT.
  - DONE: `done`=1 for one cycle, then IDLE.
- `d` holds its last driven value between transfers and after the run.
- `start` while `busy` is ignored and does not queue.
- `start` held high in IDLE starts a new run on the cycle after DONE's exit.
- `rst_n` low mid-run aborts immediately to the reset values; no `done` is produced.
- `err_count` and `iter` hold after a run until the next accepted `start`.

## Timing
- Transfer length: `delay`+4 cycles (WAIT for `delay`+1, DRIVE 1, HOLD 1, CHECK 1).
- `d` settles 1 cycle before the flip-flop samples it; `q` is compared 1 cycle after that.
- `done` is high in cycle Σ(`delay_i`+4)+1, counted from the edge that accepted `start`.
- `mismatch` lags its CHECK cycle by 1 cycle.
- `busy` and `done` are decoded from the state register (Moore outputs).

## Configuration
- `DFF_STIM_CHECK_EN` defined:
  - HOLD and CHECK states are present.
  - `mismatch` and `err_count` behave as described above.
- `DFF_STIM_CHECK_EN` undefined:
  - HOLD and CHECK are removed; DRIVE goes directly to the next WAIT, or to DONE after the last transfer.
  - Transfer length is `delay`+2 cycles.
  - `q` is unused; `mismatch`=0 and `err_count`=0 always.

## Test plan
- Reset: hold `rst_n`=0 with random inputs → all outputs at their reset values, held until release.
- Defaults, `q` driven by a real flip-flop (same `clk`), one `start` pulse:
  - delays are 5, 2, 5, 2, 1;
  - `d` takes 0, 1, 0, 1, 0;
  - `done` pulses once, 36 cycles after the start edge;
  - `err_count`=0 and `mismatch` never asserts.
- `q` tied 0, defaults: `mismatch` pulses after transfers 1 and 3; final `err_count`=2.
- `q` tied 1, with `NUM_ITER`=10 and `ERR_W`=2: `err_count` saturates at 3 and `done` still pulses once.
- `start` pulsed during WAIT of transfer 2: ignored, and there is exactly one `done`. Then assert `rst_n`=0 mid-run: outputs go to reset values immediately, no `done`. A new `start` after release gives delays 5, 2, … again.
- Build without `DFF_STIM_CHECK_EN`, defaults: `done` 26 cycles after the start edge; `err_count`=0 with `q` tied 0.
